stp_wrapper: RTL and testbench

Serial-to-parallel collector for the 32-point FFT datapath; the receiving counterpart of the parallel-to-serial output stage. Accepts one 16-bit sample per strobed cycle, assembles 32 consecutive samples into a frame, and presents the frame as 32 parallel words to the FFT core. The frame is held stable under a valid/ack handshake, so collection of the next frame proceeds while the core consumes the current one.

---
 rtl/fft_pkg.sv | 16 +
 rtl/stp_wrapper_if.sv | 46 ++++
 rtl/stp_collect.sv | 60 ++++++
 rtl/stp_wrapper.sv | 105 ++++++++++
 tb/tb_stp_wrapper.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared FFT datapath types and sizes, used by the serial/parallel
// stages and the FFT core.
package fft_pkg;

  localparam int SAMPLE_W = 16;
  localparam int N_POINTS = 32;
  localparam int IDX_W    = $clog2(N_POINTS);

  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef sample_t             frame_t [N_POINTS];
  typedef logic [IDX_W-1:0]    idx_t;

  // Index of the final sample of a frame; accepting here completes the frame.
  localparam idx_t LAST_IDX = idx_t'(N_POINTS - 1);

endpackage

// File: rtl/stp_wrapper_if.sv
// Sample/frame bus of the serial-to-parallel collector.
// The overrun flag exists only when STP_OVERRUN_EN is defined.
interface stp_wrapper_if;
  import fft_pkg::*;

  logic    in_strobe;
  sample_t serial_in;
  logic    sync;
  logic    out_ack;
  logic    out_valid;
  idx_t    fill_count;
  sample_t out1,  out2,  out3,  out4,  out5,  out6,  out7,  out8;
  sample_t out9,  out10, out11, out12, out13, out14, out15, out16;
  sample_t out17, out18, out19, out20, out21, out22, out23, out24;
  sample_t out25, out26, out27, out28, out29, out30, out31, out32;
`ifdef STP_OVERRUN_EN
  logic    overrun;
`endif

  // Collector side.
  modport slave (
    input  in_strobe, serial_in, sync, out_ack,
    output out_valid, fill_count,
    output out1,  out2,  out3,  out4,  out5,  out6,  out7,  out8,
    output out9,  out10, out11, out12, out13, out14, out15, out16,
    output out17, out18, out19, out20, out21, out22, out23, out24,
    output out25, out26, out27, out28, out29, out30, out31, out32
`ifdef STP_OVERRUN_EN
    , output overrun
`endif
  );

  // Sample source / frame consumer side.
  modport master (
    output in_strobe, serial_in, sync, out_ack,
    input  out_valid, fill_count,
    input  out1,  out2,  out3,  out4,  out5,  out6,  out7,  out8,
    input  out9,  out10, out11, out12, out13, out14, out15, out16,
    input  out17, out18, out19, out20, out21, out22, out23, out24,
    input  out25, out26, out27, out28, out29, out30, out31, out32
`ifdef STP_OVERRUN_EN
    , input overrun
`endif
  );

endinterface

// File: rtl/stp_collect.sv
// Collect stage: index counter, sync restart and the 31-word collect
// buffer. The 32nd sample of a frame is not stored here; the output bank
// takes it straight from serial_in on the completing edge (frame_done).
module stp_collect
  import fft_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    in_strobe,
  input  sample_t serial_in,
  input  logic    sync,
  output idx_t    fill_count,
  output logic    frame_done,
  output sample_t buf_words [N_POINTS-1]
);

  idx_t wr_idx;

  // Write slot (sync forces slot 0) and completion detect for this edge.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    wr_idx     = fill_count;
    frame_done = 1'b0;
    if (sync) begin
      wr_idx = '0;
    end
    if (in_strobe && !sync && (fill_count == LAST_IDX)) begin
      frame_done = 1'b1;
    end
  end

  // Index counter: advances per accept with natural 5-bit wrap; sync restarts it.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (rst) begin
      fill_count <= '0;
    end else if (in_strobe) begin
      fill_count <= wr_idx + 1'b1;
    end else if (sync) begin
      fill_count <= '0;
    end
  end

  // Collect buffer: store each accepted sample at its index (0..30).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: this buffer is register-based and reset to zero, so it is not a RAM macro.
      for (int i = 0; i < N_POINTS - 1; i++) begin
        buf_words[i] <= '0;
      end
    end else if (in_strobe) begin
      for (int i = 0; i < N_POINTS - 1; i++) begin
        if (wr_idx == idx_t'(i)) begin
          buf_words[i] <= serial_in;
        end
      end
    end
  end

endmodule

// File: rtl/stp_wrapper.sv
// Serial-to-parallel collector for the 32-point FFT. Builds 32-sample
// frames and presents them under a valid/ack handshake while the next
// frame is being collected.
// Build option STP_OVERRUN_EN: a frame completing while the previous one
// is still unacknowledged is dropped and the sticky overrun flag sets.
// Without it the newest frame overwrites the bank.
module stp_wrapper
  import fft_pkg::*;
(
  input logic          clk,
  input logic          rst,
  stp_wrapper_if.slave bus
);

  idx_t    fill_count;
  logic    frame_done;
  sample_t buf_words [N_POINTS-1];
  sample_t bank      [N_POINTS];
  logic    out_valid_q;
  logic    load;

  stp_collect u_collect (
    .clk        (clk),
    .rst        (rst),
    .in_strobe  (bus.in_strobe),
    .serial_in  (bus.serial_in),
    .sync       (bus.sync),
    .fill_count (fill_count),
    .frame_done (frame_done),
    .buf_words  (buf_words)
  );

`ifdef STP_OVERRUN_EN
  logic overrun_q;

  // A completed frame loads only if the bank is free or freed at this edge.
  always_comb begin
    load = frame_done && (!out_valid_q || bus.out_ack);
  end

  // Sticky drop flag: set on a dropped frame, cleared only by sync or reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_q <= 1'b0;
    end else if (bus.sync) begin
      overrun_q <= 1'b0;
    end else if (frame_done && out_valid_q && !bus.out_ack) begin
      overrun_q <= 1'b1;
    end
  end

  assign bus.overrun = overrun_q;
`else
  // Newest frame always wins the bank.
  always_comb begin
    load = frame_done;
  end
`endif

  // Handshake: a load sets valid (even with a same-edge ack); ack alone clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
    end else if (load) begin
      out_valid_q <= 1'b1;
    end else if (bus.out_ack) begin
      out_valid_q <= 1'b0;
    end
  end

  // Output bank: 31 buffered words plus the completing sample as the last word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_POINTS; i++) begin
        bank[i] <= '0;
      end
    end else if (load) begin
      for (int i = 0; i < N_POINTS - 1; i++) begin
        bank[i] <= buf_words[i];
      end
      bank[N_POINTS-1] <= bus.serial_in;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.fill_count = fill_count;

  assign bus.out1  = bank[0];  assign bus.out2  = bank[1];
  assign bus.out3  = bank[2];  assign bus.out4  = bank[3];
  assign bus.out5  = bank[4];  assign bus.out6  = bank[5];
  assign bus.out7  = bank[6];  assign bus.out8  = bank[7];
  assign bus.out9  = bank[8];  assign bus.out10 = bank[9];
  assign bus.out11 = bank[10]; assign bus.out12 = bank[11];
  assign bus.out13 = bank[12]; assign bus.out14 = bank[13];
  assign bus.out15 = bank[14]; assign bus.out16 = bank[15];
  assign bus.out17 = bank[16]; assign bus.out18 = bank[17];
  assign bus.out19 = bank[18]; assign bus.out20 = bank[19];
  assign bus.out21 = bank[20]; assign bus.out22 = bank[21];
  assign bus.out23 = bank[22]; assign bus.out24 = bank[23];
  assign bus.out25 = bank[24]; assign bus.out26 = bank[25];
  assign bus.out27 = bank[26]; assign bus.out28 = bank[27];
  assign bus.out29 = bank[28]; assign bus.out30 = bank[29];
  assign bus.out31 = bank[30]; assign bus.out32 = bank[31];

endmodule

// File: tb/tb_stp_wrapper.sv
// Bench for stp_wrapper: directed frames and randomized traffic compared
// every cycle against a queue-based frame model. Works in both builds
// (STP_OVERRUN_EN defined or not).
module tb_stp_wrapper;
  import fft_pkg::*;

`ifdef STP_OVERRUN_EN
  localparam bit OVR = 1'b1;
`else
  localparam bit OVR = 1'b0;
`endif

  logic tb_clk = 1'b0;
  logic rst;

  always #5 tb_clk = ~tb_clk;

  stp_wrapper_if bus ();

  stp_wrapper dut (
    .clk (tb_clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  sample_t obs [N_POINTS];
  always_comb begin
    obs = '{bus.out1,  bus.out2,  bus.out3,  bus.out4,  bus.out5,  bus.out6,  bus.out7,  bus.out8,
            bus.out9,  bus.out10, bus.out11, bus.out12, bus.out13, bus.out14, bus.out15, bus.out16,
            bus.out17, bus.out18, bus.out19, bus.out20, bus.out21, bus.out22, bus.out23, bus.out24,
            bus.out25, bus.out26, bus.out27, bus.out28, bus.out29, bus.out30, bus.out31, bus.out32};
  end

  // Reference model: samples of the partial frame in arrival order, the
  // presented frame, and the handshake/overrun flags.
  sample_t m_partial [$];
  sample_t m_bank [N_POINTS];
  bit      m_valid;
  bit      m_overrun;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_partial.delete();
    for (int i = 0; i < N_POINTS; i++) m_bank[i] = '0;
    m_valid   = 1'b0;
    m_overrun = 1'b0;
  endfunction

  // One clock edge of the model, from the inputs sampled at that edge.
  function automatic void model_edge(bit strobe, sample_t d, bit sy, bit ack);
    bit      done;
    sample_t fr [N_POINTS];
    done = 1'b0;
    if (sy) begin
      m_partial.delete();
      m_overrun = 1'b0;
    end
    if (strobe) begin
      m_partial.push_back(d);
      if (m_partial.size() == N_POINTS) begin
        done = 1'b1;
        for (int i = 0; i < N_POINTS; i++) fr[i] = m_partial[i];
        m_partial.delete();
      end
    end
    if (done) begin
      if (!m_valid || ack || !OVR) begin
        m_bank  = fr;
        m_valid = 1'b1;
      end else begin
        m_overrun = 1'b1;
      end
    end else if (ack) begin
      m_valid = 1'b0;
    end
  endfunction

  task automatic compare_all(input string tag);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'(m_valid));
    check({tag, "_fill"}, 32'(bus.fill_count), 32'(m_partial.size()));
`ifdef STP_OVERRUN_EN
    check({tag, "_overrun"}, 32'(bus.overrun), 32'(m_overrun));
`endif
    for (int i = 0; i < N_POINTS; i++) begin
      check($sformatf("%s_out%0d", tag, i + 1), 32'(obs[i]), 32'(m_bank[i]));
    end
  endtask

  // Drive one cycle from a negedge, advance the model at the posedge,
  // compare at the following negedge.
  task automatic step(input bit strobe, input sample_t d, input bit sy, input bit ack);
    bus.in_strobe = strobe;
    bus.serial_in = d;
    bus.sync      = sy;
    bus.out_ack   = ack;
    @(posedge tb_clk);
    model_edge(strobe, d, sy, ack);
    @(negedge tb_clk);
    compare_all("cyc");
  endtask

  task automatic send(input int n, input sample_t base, input bit gaps, input bit ack_last);
    for (int k = 0; k < n; k++) begin
      step(1'b1, sample_t'(base + k), 1'b0, ack_last && (k == n - 1));
      if (gaps) step(1'b0, sample_t'($urandom), 1'b0, 1'b0);
    end
  endtask

  // Reset asserted between edges; outputs must clear before any clock edge.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    compare_all("async_rst");
    @(posedge tb_clk);
    @(negedge tb_clk);
    rst = 1'b0;
    compare_all("post_rst");
  endtask

  initial begin
    bus.in_strobe = 1'b0;
    bus.serial_in = '0;
    bus.sync      = 1'b0;
    bus.out_ack   = 1'b0;
    rst           = 1'b1;
    model_reset();
    repeat (2) @(negedge tb_clk);
    rst = 1'b0;
    compare_all("reset");

    // Contiguous frame 0..31.
    send(31, 16'h0000, 1'b0, 1'b0);
    check("t1_valid_before_last", 32'(bus.out_valid), 32'd0);
    send(1, 16'h001F, 1'b0, 1'b0);
    check("t1_valid", 32'(bus.out_valid), 32'd1);
    check("t1_out1", 32'(obs[0]), 32'h0000);
    check("t1_out32", 32'(obs[31]), 32'h001F);
    check("t1_fill", 32'(bus.fill_count), 32'd0);
    step(1'b0, '0, 1'b0, 1'b1);
    check("t1_acked", 32'(bus.out_valid), 32'd0);

    // Same frame with a gap after every strobe.
    send(32, 16'h0000, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);

    // Partial frame discarded by sync.
    send(10, 16'h5000, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    send(32, 16'hA000, 1'b0, 1'b0);
    check("t3_out11", 32'(obs[10]), 32'h0000A00A);
    step(1'b0, '0, 1'b0, 1'b1);

    // sync together with the 32nd strobe: no completion, fill becomes 1.
    send(31, 16'h7000, 1'b0, 1'b0);
    step(1'b1, 16'h7777, 1'b1, 1'b0);
    check("t4_fill_sync", 32'(bus.fill_count), 32'd1);
    check("t4_no_valid", 32'(bus.out_valid), 32'd0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Two back-to-back frames without ack, then ack, then sync.
    send(32, 16'hB000, 1'b0, 1'b0);
    send(32, 16'hC000, 1'b0, 1'b0);
    check("t5_out1", 32'(obs[0]), OVR ? 32'h0000B000 : 32'h0000C000);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);

    // Completion with same-edge ack while a frame is still presented.
    send(32, 16'hE000, 1'b0, 1'b0);
    send(32, 16'hD000, 1'b0, 1'b1);
    check("t6_valid", 32'(bus.out_valid), 32'd1);
    check("t6_out32", 32'(obs[31]), 32'h0000D01F);
    step(1'b0, '0, 1'b0, 1'b1);

    // Asynchronous reset after 20 strobes, then a clean frame.
    send(20, 16'h3000, 1'b0, 1'b0);
    async_reset();
    send(32, 16'h4000, 1'b0, 1'b0);
    check("t7_out1", 32'(obs[0]), 32'h00004000);
    step(1'b0, '0, 1'b0, 1'b1);

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      step($urandom_range(0, 3) != 0, sample_t'($urandom), $urandom_range(0, 99) == 0,
           $urandom_range(0, 15) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
